// File: rtl/aes_engine_ctrl_pkg.sv
// Shared types and constants for the AES engine control sequencer.
package aes_engine_ctrl_pkg;

    localparam int AES_NB_WORDS = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CORE,
        STORE,
        DONE
    } aes_ctrl_state_e;

    typedef struct packed {
        logic        start;
        logic [15:0] num_blocks;
    } aes_ctrl_cfg_t;

endpackage

// File: rtl/aes_engine_ctrl.sv
// Job sequencer for the AES datapath: load a block, run the core, stream the
// block out, repeat for the programmed block count, then pulse done.
module aes_engine_ctrl
    import aes_engine_ctrl_pkg::*;
#(
    parameter int  NB_WORDS  = AES_NB_WORDS,
    parameter int  BLK_CNT_W = 16,
    localparam int WCNT_W    = $clog2(NB_WORDS)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 start_i,
    input  logic [BLK_CNT_W-1:0] num_blocks_i,
    input  logic                 in_hs_i,
    input  logic                 out_ready_i,
    input  logic                 core_done_i,
    output logic [WCNT_W-1:0]    request_counter_o,
    output logic                 data_out_valid_o,
    output logic                 clear_o,
    output logic                 core_start_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [BLK_CNT_W-1:0] blk_cnt_o
);

    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NB_WORDS - 1);

    aes_ctrl_state_e      state_q, state_d;
    logic [WCNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic [BLK_CNT_W-1:0] blk_cnt_q, blk_cnt_d;
    logic [BLK_CNT_W-1:0] num_blocks_q, num_blocks_d;
    logic [BLK_CNT_W-1:0] blk_cnt_inc;
    logic                 clear_q, clear_d;
    logic                 core_start_q, core_start_d;
    logic                 done_q, done_d;

    assign blk_cnt_inc = blk_cnt_q + BLK_CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        blk_cnt_d    = blk_cnt_q;
        num_blocks_d = num_blocks_q;
        clear_d      = 1'b0;
        core_start_d = 1'b0;
        done_d       = 1'b0;

        if (clear_i) begin
            state_d      = IDLE;
            word_cnt_d   = '0;
            blk_cnt_d    = '0;
            num_blocks_d = '0;
            clear_d      = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        num_blocks_d = num_blocks_i;
                        word_cnt_d   = '0;
                        blk_cnt_d    = '0;
                        // An empty job completes immediately without touching the datapath.
                        if (num_blocks_i != '0) begin
                            state_d = LOAD;
                            clear_d = 1'b1;
                        end else begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (in_hs_i) begin
                        if (word_cnt_q == LAST_WORD) begin
                            word_cnt_d   = '0;
                            state_d      = CORE;
                            core_start_d = 1'b1;
                        end else begin
                            word_cnt_d = word_cnt_q + WCNT_W'(1);
                        end
                    end
                end
                CORE: begin
                    if (core_done_i) state_d = STORE;
                end
                STORE: begin
                    if (out_ready_i) begin
                        if (word_cnt_q == LAST_WORD) begin
                            word_cnt_d = '0;
                            blk_cnt_d  = blk_cnt_inc;
                            if (blk_cnt_inc == num_blocks_q) begin
                                state_d = DONE;
                                done_d  = 1'b1;
                            end else begin
                                state_d = LOAD;
                            end
                        end else begin
                            word_cnt_d = word_cnt_q + WCNT_W'(1);
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            word_cnt_q   <= '0;
            blk_cnt_q    <= '0;
            num_blocks_q <= '0;
            clear_q      <= 1'b0;
            core_start_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            blk_cnt_q    <= blk_cnt_d;
            num_blocks_q <= num_blocks_d;
            clear_q      <= clear_d;
            core_start_q <= core_start_d;
            done_q       <= done_d;
        end
    end

    assign request_counter_o = word_cnt_q;
    assign data_out_valid_o  = (state_q == STORE);
    assign busy_o            = (state_q != IDLE);
    assign clear_o           = clear_q;
    assign core_start_o      = core_start_q;
    assign done_o            = done_q;
    assign blk_cnt_o         = blk_cnt_q;

endmodule

// File: tb/tb_aes_engine_ctrl.sv
// Directed bench for aes_engine_ctrl with a count-based job model checked every cycle.
module tb_aes_engine_ctrl;

    localparam int NB  = 4;
    localparam int BW  = 4;
    localparam int WW  = $clog2(NB);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear_i, start_i, in_hs_i, out_ready_i, core_done_i;
    logic [BW-1:0] num_blocks_i;
    logic [WW-1:0] request_counter_o;
    logic          data_out_valid_o, clear_o, core_start_o, busy_o, done_o;
    logic [BW-1:0] blk_cnt_o;

    aes_engine_ctrl #(.NB_WORDS(NB), .BLK_CNT_W(BW)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .clear_i           (clear_i),
        .start_i           (start_i),
        .num_blocks_i      (num_blocks_i),
        .in_hs_i           (in_hs_i),
        .out_ready_i       (out_ready_i),
        .core_done_i       (core_done_i),
        .request_counter_o (request_counter_o),
        .data_out_valid_o  (data_out_valid_o),
        .clear_o           (clear_o),
        .core_start_o      (core_start_o),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .blk_cnt_o         (blk_cnt_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Job model in terms of words moved and blocks finished.
    int m_busy, m_fin, m_loaded, m_computing, m_stored, m_blocks, m_target;
    int e_clear, e_start, e_done;
    int hs_cnt = 0, cs_cnt = 0, done_cnt = 0, clr_cnt = 0;
    int idx_q[$];

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_fin = 0; m_loaded = 0; m_computing = 0;
            m_stored = 0; m_blocks = 0; m_target = 0;
            e_clear = 0; e_start = 0; e_done = 0;
        end else begin
            if (data_out_valid_o && out_ready_i) begin
                hs_cnt++;
                idx_q.push_back(int'(request_counter_o));
            end
            e_clear = 0; e_start = 0; e_done = 0;
            if (clear_i) begin
                m_busy = 0; m_fin = 0; m_loaded = 0; m_computing = 0;
                m_stored = 0; m_blocks = 0; m_target = 0;
                e_clear = 1;
            end else if (!m_busy) begin
                if (start_i) begin
                    m_target = int'(num_blocks_i);
                    m_blocks = 0; m_loaded = 0; m_stored = 0;
                    m_busy = 1;
                    if (m_target != 0) e_clear = 1;
                    else begin m_fin = 1; e_done = 1; end
                end
            end else if (m_fin) begin
                m_busy = 0; m_fin = 0;
            end else if (m_loaded < NB) begin
                if (in_hs_i) begin
                    m_loaded++;
                    if (m_loaded == NB) begin m_computing = 1; e_start = 1; end
                end
            end else if (m_computing) begin
                if (core_done_i) m_computing = 0;
            end else if (out_ready_i) begin
                m_stored++;
                if (m_stored == NB) begin
                    m_blocks++; m_loaded = 0; m_stored = 0;
                    if (m_blocks == m_target) begin m_fin = 1; e_done = 1; end
                end
            end
        end
        #1;
        chk("req_idx",   int'(request_counter_o), (m_loaded == NB) ? m_stored : m_loaded);
        chk("out_valid", int'(data_out_valid_o),
            (m_busy && !m_fin && m_loaded == NB && !m_computing) ? 1 : 0);
        chk("clear_o",   int'(clear_o), e_clear);
        chk("core_start",int'(core_start_o), e_start);
        chk("busy",      int'(busy_o), m_busy);
        chk("done",      int'(done_o), e_done);
        chk("blk_cnt",   int'(blk_cnt_o), m_blocks);
        if (core_start_o) cs_cnt++;
        if (done_o)       done_cnt++;
        if (clear_o)      clr_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start(input int nb);
        start_i = 1'b1; num_blocks_i = BW'(nb);
        cyc(1);
        start_i = 1'b0; num_blocks_i = '0;
    endtask

    task automatic feed(input bit bubbles);
        int n = 0;
        while (n < NB) begin
            if (bubbles && $urandom_range(0, 2) == 0) in_hs_i = 1'b0;
            else begin in_hs_i = 1'b1; n++; end
            cyc(1);
        end
        in_hs_i = 1'b0;
    endtask

    task automatic core(input int dly);
        cyc(dly);
        core_done_i = 1'b1;
        cyc(1);
        core_done_i = 1'b0;
    endtask

    task automatic drain(input int period);
        int base = hs_cnt;
        int i = 0;
        while (hs_cnt - base < NB && i < 200) begin
            out_ready_i = (i % period == 0);
            cyc(1);
            i++;
        end
        out_ready_i = 1'b0;
        if (i >= 200) chk("drain_timeout", hs_cnt - base, NB);
    endtask

    int b_cs, b_hs, b_done, b_clr;
    task automatic snap();
        b_cs = cs_cnt; b_hs = hs_cnt; b_done = done_cnt; b_clr = clr_cnt;
    endtask

    initial begin
        rst_n = 1'b0; clear_i = 0; start_i = 0; in_hs_i = 0; out_ready_i = 0;
        core_done_i = 0; num_blocks_i = '0;
        #1;
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_valid", int'(data_out_valid_o), 0);
        chk("rst_blk", int'(blk_cnt_o), 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        // Single block, back-to-back input, core done 3 cycles after start.
        snap(); idx_q.delete();
        do_start(1);
        chk("t1_clear_now", int'(clear_o), 1);
        feed(0);
        chk("t1_cstart_now", int'(core_start_o), 1);
        core(3);
        drain(1);
        chk("t1_done_next", int'(done_o), 1);
        chk("t1_hs", hs_cnt - b_hs, 4);
        chk("t1_idx_n", idx_q.size(), 4);
        for (int i = 0; i < 4 && i < idx_q.size(); i++) chk("t1_idx_seq", idx_q[i], i);
        cyc(1);
        chk("t1_done_once", done_cnt - b_done, 1);
        chk("t1_clr_once", clr_cnt - b_clr, 1);
        chk("t1_blk", int'(blk_cnt_o), 1);
        chk("t1_idle", int'(busy_o), 0);
        cyc(2);

        // Back-pressure: ready 1,0,0,1,0,0,...
        snap(); idx_q.delete();
        do_start(1); feed(0); core(1);
        drain(3);
        chk("t2_hs", hs_cnt - b_hs, 4);
        for (int i = 0; i < 4 && i < idx_q.size(); i++) chk("t2_idx_seq", idx_q[i], i);
        cyc(2);

        // Three blocks with input bubbles.
        snap();
        do_start(3);
        repeat (3) begin feed(1); core(2); drain(2); end
        cyc(1);
        chk("t3_cstart", cs_cnt - b_cs, 3);
        chk("t3_hs", hs_cnt - b_hs, 12);
        chk("t3_blk", int'(blk_cnt_o), 3);
        chk("t3_done", done_cnt - b_done, 1);
        cyc(2);

        // Zero-block start, then a start pulse while the core runs.
        snap();
        do_start(0);
        chk("t4_zero_done", int'(done_o), 1);
        chk("t4_zero_blk", int'(blk_cnt_o), 0);
        cyc(2);
        chk("t4_zero_cs", cs_cnt - b_cs, 0);
        chk("t4_zero_clr", clr_cnt - b_clr, 0);
        chk("t4_zero_done_n", done_cnt - b_done, 1);
        snap();
        do_start(1); feed(0);
        start_i = 1'b1; num_blocks_i = BW'(5);
        cyc(1);
        start_i = 1'b0; num_blocks_i = '0;
        core(2); drain(1); cyc(1);
        chk("t4_ign_blk", int'(blk_cnt_o), 1);
        chk("t4_ign_done", done_cnt - b_done, 1);
        chk("t4_ign_clr", clr_cnt - b_clr, 1);
        cyc(2);

        // Clear in STORE at word 2, then async reset in LOAD.
        snap();
        do_start(2); feed(0); core(1);
        out_ready_i = 1'b1; cyc(2);
        out_ready_i = 1'b0; clear_i = 1'b1;
        cyc(1);
        clear_i = 1'b0;
        chk("t5_clr_o", int'(clear_o), 1);
        chk("t5_clr_busy", int'(busy_o), 0);
        chk("t5_clr_idx", int'(request_counter_o), 0);
        cyc(2);
        chk("t5_clr_nodone", done_cnt - b_done, 0);
        do_start(1);
        in_hs_i = 1'b1; cyc(2); in_hs_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_idx", int'(request_counter_o), 0);
        chk("t5_rst_busy", int'(busy_o), 0);
        chk("t5_rst_clr", int'(clear_o), 0);
        chk("t5_rst_valid", int'(data_out_valid_o), 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        chk("t5_rst_nodone", done_cnt - b_done, 0);

        // Clear and start together; core done coincident with core start.
        start_i = 1'b1; num_blocks_i = BW'(1); clear_i = 1'b1;
        cyc(1);
        start_i = 1'b0; num_blocks_i = '0; clear_i = 1'b0;
        chk("t6_cs_busy", int'(busy_o), 0);
        cyc(2);
        chk("t6_cs_idle", int'(busy_o), 0);
        do_start(1); feed(0);
        core_done_i = 1'b1; cyc(1); core_done_i = 1'b0;
        chk("t6_coinc_store", int'(data_out_valid_o), 1);
        drain(1); cyc(2);

        // Largest block count completes without wrap.
        snap();
        do_start(15);
        in_hs_i = 1'b1; core_done_i = 1'b1; out_ready_i = 1'b1;
        for (int i = 0; i < 400 && done_cnt == b_done; i++) cyc(1);
        in_hs_i = 1'b0; core_done_i = 1'b0; out_ready_i = 1'b0;
        chk("t7_done", done_cnt - b_done, 1);
        chk("t7_blk", int'(blk_cnt_o), 15);
        chk("t7_cstart", cs_cnt - b_cs, 15);
        chk("t7_hs", hs_cnt - b_hs, 60);
        cyc(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
